// File: rtl/reg_obs_scanner_pkg.sv
// ============================================================================
// reg_obs_scanner_pkg : shared widths and scanner FSM state encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_obs_scanner_pkg;

   localparam int c_reg_idx_w_def = 5;
   localparam int c_data_w_def    = 32;

   typedef enum logic [2:0] {
      OBS_IDLE   = 3'd0,
      OBS_SETTLE = 3'd1,
      OBS_SAMPLE = 3'd2,
      OBS_DRAIN  = 3'd3,
      OBS_DONE   = 3'd4
   } obs_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_obs_scanner_if.sv
// ============================================================================
// reg_obs_scanner_if : register-observation select/data plus output stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_obs_scanner_if
   import reg_obs_scanner_pkg::*;
#(
   parameter int SEL_W  = c_reg_idx_w_def,
   parameter int DATA_W = c_data_w_def
);
   logic              start;
   logic              busy;
   logic              done;
   logic [SEL_W-1:0]  reg_obs_sel;
   logic [DATA_W-1:0] reg_obs_data;
   logic              out_valid;
   logic              out_ready;
   logic [SEL_W-1:0]  out_idx;
   logic [DATA_W-1:0] out_data;

   modport master (
      input  start, reg_obs_data, out_ready,
      output busy, done, reg_obs_sel, out_valid, out_idx, out_data
   );

   modport slave (
      output start, reg_obs_data, out_ready,
      input  busy, done, reg_obs_sel, out_valid, out_idx, out_data
   );
endinterface

`default_nettype wire

// File: rtl/reg_obs_scanner_fifo.sv
// ============================================================================
// obs_fifo : show-ahead FIFO holding captured {index, data} pairs
// Revision: 1.0
// ============================================================================
`default_nettype none

module obs_fifo
   import reg_obs_scanner_pkg::*;
#(
   parameter int WIDTH = c_reg_idx_w_def + c_data_w_def,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             push_i,
   input  wire logic [WIDTH-1:0] data_i,
   input  wire logic             pop_i,
   output logic      [WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int c_aw = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [c_aw:0]      wr_q, rd_q;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic               do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[c_aw] != rd_q[c_aw]) &&
                    (wr_q[c_aw-1:0] == rd_q[c_aw-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[c_aw-1:0]] <= data_i;
   end

   // An empty FIFO presents zeros so the head reads clean out of reset.
   assign data_o = empty_o ? '0 : mem_q[rd_q[c_aw-1:0]];

endmodule

`default_nettype wire

// File: rtl/reg_obs_scanner.sv
// ============================================================================
// reg_obs_scanner : sweeps cpu_top observed registers and streams the samples
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_obs_scanner
   import reg_obs_scanner_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int SEL_W      = c_reg_idx_w_def,
   parameter int DATA_W     = c_data_w_def,
   parameter int SETTLE     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   reg_obs_scanner_if.master bus
);
   localparam int               c_cnt_w  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SEL_W-1:0] c_last   = SEL_W'(NUM_REGS - 1);
   localparam logic [c_cnt_w-1:0] c_settle = c_cnt_w'(SETTLE);
   localparam obs_state_e       c_after_sel = (SETTLE > 0) ? OBS_SETTLE : OBS_SAMPLE;

   obs_state_e           state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic                 push, pop, full, empty;
   logic [SEL_W+DATA_W-1:0] head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OBS_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      case (state_q)
         OBS_IDLE: begin
            if (bus.start) begin
               sel_d   = '0;
               cnt_d   = c_settle;
               state_d = c_after_sel;
            end
         end
         OBS_SETTLE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= c_cnt_w'(1)) state_d = OBS_SAMPLE;
         end
         OBS_SAMPLE: begin
            // Full is judged before any same-cycle pop, so a stall lasts one extra cycle.
            if (!full) begin
               push = 1'b1;
               if (sel_q == c_last) begin
                  state_d = OBS_DRAIN;
               end else begin
                  sel_d   = sel_q + 1'b1;
                  cnt_d   = c_settle;
                  state_d = c_after_sel;
               end
            end
         end
         OBS_DRAIN: begin
            if (empty) state_d = OBS_DONE;
         end
         OBS_DONE: begin
            sel_d   = '0;
            state_d = OBS_IDLE;
         end
         default: state_d = OBS_IDLE;
      endcase
   end

   obs_fifo #(
      .WIDTH (SEL_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  ({sel_q, bus.reg_obs_data}),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign pop                        = bus.out_valid && bus.out_ready;
   assign bus.out_valid              = !empty;
   assign {bus.out_idx, bus.out_data} = head;
   assign bus.reg_obs_sel            = sel_q;
   assign bus.busy                   = (state_q != OBS_IDLE);
   assign bus.done                   = (state_q == OBS_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_obs_scanner.sv
// ============================================================================
// tb_reg_obs_scanner : directed + randomized checks of the register scanner
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_obs_scanner;
   localparam int N = 32;

   logic        clk;
   logic        rst_n;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        rdy_rand, rdy_force, regmode1;
   logic [31:0] base1, base2, dq1, dq2;
   logic [36:0] got1[$];
   logic [36:0] got2[$];
   int          last_cyc = -1;
   int          done1_total = 0;

   reg_obs_scanner_if #(.SEL_W(5), .DATA_W(32)) bus1 ();
   reg_obs_scanner_if #(.SEL_W(5), .DATA_W(32)) bus2 ();

   reg_obs_scanner #(.NUM_REGS(N), .SEL_W(5), .DATA_W(32), .SETTLE(1), .FIFO_DEPTH(4))
      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   reg_obs_scanner #(.NUM_REGS(N), .SEL_W(5), .DATA_W(32), .SETTLE(0), .FIFO_DEPTH(4))
      u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   function automatic logic [31:0] f(input logic [31:0] b, input logic [4:0] s);
      return b + 32'(s) * 32'd4;
   endfunction

   // cpu_top stand-ins: combinational read, or a read registered one cycle late.
   assign bus1.reg_obs_data = regmode1 ? dq1 : f(base1, bus1.reg_obs_sel);
   assign bus2.reg_obs_data = dq2;
   assign bus2.out_ready    = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
      dq1 <= f(base1, bus1.reg_obs_sel);
      dq2 <= f(base2, bus2.reg_obs_sel);
   end

   initial forever begin
      @(posedge clk);
      #1;
      bus1.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   initial forever begin
      @(negedge clk);
      if (bus1.out_valid && bus1.out_ready) begin
         got1.push_back({bus1.out_idx, bus1.out_data});
         if (bus1.out_idx == 5'(N - 1)) last_cyc = cyc;
      end
      if (bus1.done) done1_total++;
      if (bus2.out_valid && bus2.out_ready) got2.push_back({bus2.out_idx, bus2.out_data});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected sweep: every index once, ascending; a lagged read returns the previous index's value.
   task automatic check_words(input string tag, input logic [36:0] q[$], input int ix,
                              input logic [31:0] base, input bit lag);
      logic [36:0] got;
      logic [36:0] exp;
      int          src;
      check($sformatf("%s_count", tag), 64'(q.size() - ix), 64'(N));
      for (int k = 0; k < N; k++) begin
         got = (ix + k < q.size()) ? q[ix + k] : 37'h0;
         src = (lag && k > 0) ? k - 1 : k;
         exp = {5'(k), f(base, 5'(src))};
         check($sformatf("%s_w%0d", tag, k), 64'(got), 64'(exp));
      end
   endtask

   task automatic pulse1(output int st);
      bus1.start = 1'b1;
      st = cyc;
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
   endtask

   task automatic wait_done1(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus1.done && n < budget);
      check(tag, 64'(bus1.done), 64'd1);
   endtask

   initial begin
      int ix, st, d0, n;
      rst_n = 1'b1;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      rdy_rand = 1'b0;
      rdy_force = 1'b1;
      regmode1 = 1'b0;
      base1 = 32'hA000_0000;
      base2 = 32'h0;

      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 64'(bus1.busy), 64'd0);
      check("rst_done", 64'(bus1.done), 64'd0);
      check("rst_valid", 64'(bus1.out_valid), 64'd0);
      check("rst_sel", 64'(bus1.reg_obs_sel), 64'd0);
      check("rst_idx", 64'(bus1.out_idx), 64'd0);
      check("rst_data", 64'(bus1.out_data), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Full sweep, consumer always ready.
      ix = got1.size();
      d0 = done1_total;
      pulse1(st);
      wait_done1(200, "sweep_done");
      check("sweep_busy_at_done", 64'(bus1.busy), 64'd1);
      @(negedge clk);
      check("sweep_busy_fall", 64'(bus1.busy), 64'd0);
      check("sweep_done_width", 64'(bus1.done), 64'd0);
      check("sweep_done_count", 64'(done1_total - d0), 64'd1);
      check("sweep_last_push_time", 64'(last_cyc - st), 64'd65);
      check_words("sweep", got1, ix, base1, 1'b0);

      // Backpressure: ready low holds four words and stalls on index 4.
      base1 = $urandom();
      rdy_force = 1'b0;
      @(posedge clk);
      #2;
      ix = got1.size();
      pulse1(st);
      repeat (40) @(negedge clk);
      check("bp_sel", 64'(bus1.reg_obs_sel), 64'd4);
      check("bp_busy", 64'(bus1.busy), 64'd1);
      check("bp_valid", 64'(bus1.out_valid), 64'd1);
      check("bp_head_idx", 64'(bus1.out_idx), 64'd0);
      check("bp_head_data", 64'(bus1.out_data), 64'(f(base1, 5'd0)));
      check("bp_none_popped", 64'(got1.size() - ix), 64'd0);
      @(posedge clk);
      #2 rdy_rand = 1'b1;
      wait_done1(3000, "bp_done");
      @(negedge clk);
      check_words("bp", got1, ix, base1, 1'b0);

      // Registered read with SETTLE=1 lines up.
      regmode1 = 1'b1;
      base1 = $urandom();
      repeat (3) @(posedge clk);
      #1;
      ix = got1.size();
      pulse1(st);
      wait_done1(3000, "reg1_done");
      @(negedge clk);
      check_words("reg1", got1, ix, base1, 1'b0);

      // Same registered read with SETTLE=0 captures the previous index's value.
      base2 = $urandom();
      repeat (3) @(posedge clk);
      #1;
      ix = got2.size();
      bus2.start = 1'b1;
      @(posedge clk);
      #1 bus2.start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus2.done && n < 300);
      check("reg0_done", 64'(bus2.done), 64'd1);
      @(negedge clk);
      check_words("reg0", got2, ix, base2, 1'b1);

      // Second start while busy is ignored.
      rdy_rand = 1'b0;
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
      ix = got1.size();
      d0 = done1_total;
      pulse1(st);
      repeat (8) @(posedge clk);
      #1 bus1.start = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      wait_done1(300, "busy_start_done");
      repeat (100) @(negedge clk);
      check("busy_start_idle", 64'(bus1.busy), 64'd0);
      check("busy_start_done_count", 64'(done1_total - d0), 64'd1);
      check_words("busy_start", got1, ix, base1, 1'b0);

      // Reset mid-sweep, then a clean restart from index 0.
      pulse1(st);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus1.reg_obs_sel != 5'd12 && n < 200);
      check("mid_reached_sel12", 64'(bus1.reg_obs_sel), 64'd12);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus1.out_valid), 64'd0);
      check("mid_rst_busy", 64'(bus1.busy), 64'd0);
      check("mid_rst_sel", 64'(bus1.reg_obs_sel), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mid_post_valid", 64'(bus1.out_valid), 64'd0);
      ix = got1.size();
      pulse1(st);
      wait_done1(300, "mid_restart_done");
      @(negedge clk);
      check_words("mid_restart", got1, ix, base1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_obs_scanner.md
Name: reg_obs_scanner

Overview:
- Initiator side of the CPU register-observation interface: drives `reg_obs_sel` and samples the `reg_obs_data` that `cpu_top` returns.
- Sweeps register indices 0..NUM_REGS-1 on a start pulse and waits a settle time after each select change.
- Captures each {index, data} pair into a small show-ahead FIFO and streams the pairs out over a valid/ready port.
- Sits beside `cpu_top` in the test/debug harness and replaces free-running manual selection of observed registers.

Parameters:
- NUM_REGS, 32, number of registers swept (indices 0..NUM_REGS-1).
- SEL_W, 5, width of the register index.
- DATA_W, 32, width of observed data.
- SETTLE, 1, idle cycles between a select change and its sample (0 allowed).
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse once the last word has left the output port.
- reg_obs_sel  out  SEL_W  register index presented to cpu_top; registered.
- reg_obs_data  in  DATA_W  observed register value, combinational from cpu_top.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_idx  out  SEL_W  index of the head word.
- out_data  out  DATA_W  data of the head word.

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE; busy=0, done=0, reg_obs_sel=0, out_valid=0.
  - out_idx=0, out_data=0; FIFO flushed, settle counter=0.
  - A reset mid-sweep drops every buffered word. No partial output survives.
- FSM states: IDLE, SETTLE, SAMPLE, DRAIN, DONE.
- IDLE:
  - On start=1, set reg_obs_sel<=0 and cnt<=SETTLE.
  - Go to SETTLE when SETTLE>0, otherwise go to SAMPLE.
- SETTLE:
  - reg_obs_sel held; cnt decrements each cycle.
  - When cnt==1 (or SETTLE==0), go to SAMPLE.
- SAMPLE:
  - If the FIFO is not full, push {reg_obs_sel, reg_obs_data}.
  - Full is evaluated before any same-cycle pop, so there is no push when full even if a pop occurs.
  - On a push with sel==NUM_REGS-1, go to DRAIN.
  - On any other push, sel<=sel+1, cnt<=SETTLE, and go to SETTLE (or stay in SAMPLE when SETTLE==0).
  - If the FIFO is full, stall in SAMPLE with sel held and no sample taken.
- DRAIN: wait for FIFO empty, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. reg_obs_sel returns to 0 in IDLE.
- busy=1 in SETTLE, SAMPLE, DRAIN and DONE.
- Throughput without backpressure: SETTLE+1 cycles per register; the full sweep takes NUM_REGS*(SETTLE+1) cycles. Default: 64 cycles from accepted start to last push.
- Output port:
  - out_valid = FIFO not empty; out_idx and out_data show the FIFO head.
  - Pop on out_valid && out_ready.
  - Head is stable while out_valid=1 and out_ready=0.
- Ordering: words leave in strictly ascending index, each index exactly once per sweep.
- Index arithmetic: sel increments are SEL_W-bit. The terminal check uses NUM_REGS-1, so there is no wrap.
- Simultaneous events: start in the same cycle as done is ignored; start is accepted only in IDLE.

Decomposition:
- Shared include (the existing `variables.vh`):
  - REG_IDX_W / DATA_W defaults.
  - FSM state encodings `OBS_IDLE` .. `OBS_DONE` as 3-bit localparam/defines.
- One sub-module: `obs_fifo` (parameterised width/depth, show-ahead, push/pop/full/empty, async active-low reset flush).
- FSM and counter live in `reg_obs_scanner`.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> busy=0, done=0, out_valid=0, reg_obs_sel=0 immediately, without waiting for a clock edge.
- Full sweep:
  - Stimulus: model data=32'hA000_0000+4*sel, out_ready=1, start pulse.
  - Response: 32 words, idx 0..31 in order with matching data; last push 64 cycles after start; done pulses once; busy falls the cycle after done.
- Backpressure: out_ready=0 throughout -> 4 words buffered; sel holds at 4 and busy stays 1. Release out_ready -> all 32 words delivered with none lost or duplicated.
- Settle check: model data updated 1 cycle after the sel change (registered read), SETTLE=1 -> every captured value matches its index. With SETTLE=0 the same model yields the mismatch the bench expects.
- Start while busy: second start at cycle 10 -> exactly 32 words and one done pulse.
- Reset mid-sweep: assert rst_n=0 when sel=12 -> FIFO empty and out_valid=0. A new start restarts at idx 0 and delivers 32 words.
